rr_arb8: RTL and testbench

RR_ARB8 -- requirements
Module: rr_arb8

---
 rtl/rr_arb_pkg.sv | 14 +
 rtl/rr_pick8.sv | 28 ++
 rtl/rr_arb8.sv | 102 ++++++++++
 tb/tb_rr_arb8.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// Holds the FSM state enum and requester count / index width.
package rr_arb_pkg;

  localparam int NREQ = 8;
  localparam int IDW  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority search: first set req bit at or above ptr, wrapping 7->0.
// Ports: req[7:0], ptr[2:0] in; any (some request set), idx[2:0] out.
import rr_arb_pkg::*;

module rr_pick8 (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] j;

  // Walk from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = ptr + IDW'(k);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with registered one-hot grant and hold timeout.
// Ports: clk, rst (async high), en, req[7:0], done in; gnt, gnt_id, gnt_vld, timeout out.
import rr_arb_pkg::*;

module rr_arb8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_vld,
  output logic            timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t          state, state_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [7:0]      hold, hold_n;
  logic [NREQ-1:0] gnt_n;
  logic [IDW-1:0]  id_n;
  logic            vld_n;
  logic            to_n;
  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic            rel;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Voluntary release; wins over the forced one.
  assign rel = done | ~req[gnt_id];

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold;
    gnt_n   = gnt;
    id_n    = gnt_id;
    vld_n   = gnt_vld;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && pick_any) begin
          state_n = GRANT;
          gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          id_n    = pick_idx;
          vld_n   = 1'b1;
          ptr_n   = pick_idx + 1'b1;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (rel || hold == HOLD_LAST) begin
          state_n = RELEASE;
          gnt_n   = '0;
          vld_n   = 1'b0;
          to_n    = ~rel;
        end else if (hold != 8'hFF) begin
          hold_n = hold + 8'd1;
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        vld_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      hold    <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      hold    <= hold_n;
      gnt     <= gnt_n;
      gnt_id  <= id_n;
      gnt_vld <= vld_n;
      timeout <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8 (MAX_HOLD=4) with a behavioural model.
// Directed scenarios plus a randomized run compared cycle by cycle.
module tb_rr_arb8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  int n_chk = 0;
  int n_fail = 0;

  // model: busy = owner holds grant, rls = in the one-cycle gap after
  int  m_ptr, m_owner, m_hold;
  bit  m_busy, m_rls, m_to;
  logic [7:0] m_gnt;

  rr_arb8 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ptr = 0; m_owner = 0; m_hold = 0;
    m_busy = 0; m_rls = 0; m_to = 0;
    m_gnt = '0;
  endfunction

  function automatic void model_edge();
    int w;
    bit found;
    m_to = 0;
    if (m_rls) begin
      m_rls = 0;
    end else if (m_busy) begin
      if (done || !req[m_owner]) begin
        m_busy = 0; m_rls = 1;
      end else if (m_hold == MH - 1) begin
        m_busy = 0; m_rls = 1; m_to = 1;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end else if (en) begin
      found = 0;
      w = 0;
      for (int k = 0; k < 8; k++)
        if (!found && req[(m_ptr + k) % 8]) begin
          found = 1; w = (m_ptr + k) % 8;
        end
      if (found) begin
        m_busy = 1; m_owner = w;
        m_ptr = (w + 1) % 8; m_hold = 0;
      end
    end
    m_gnt = m_busy ? (8'd1 << m_owner) : 8'd0;
  endfunction

  task automatic step();
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    en = 0; req = '0; done = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1;
    #2;
    n_chk++;
    if (gnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_gnt got %h want 00", gnt);
    end
    n_chk++;
    if (gnt_vld !== 1'b0 || timeout !== 1'b0 || gnt_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_flags got vld=%b to=%b id=%0d want 0 0 0",
               gnt_vld, timeout, gnt_id);
    end
    reset_dut();
  endtask

  task automatic test_basic();
    reset_dut();
    req = 8'h01; en = 1;
    step();
    n_chk++;
    if (gnt !== 8'h01 || gnt_id !== 3'd0 || gnt_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_grant got gnt=%h id=%0d vld=%b want 01 0 1",
               gnt, gnt_id, gnt_vld);
    end
    done = 1;
    step();
    n_chk++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release got gnt=%h vld=%b to=%b want 00 0 0",
               gnt, gnt_vld, timeout);
    end
    done = 0; req = 8'h00;
    step();
    n_chk++;
    if (gnt !== 8'h00) begin
      n_fail++; $display("FAIL basic_idle got %h want 00", gnt);
    end
    req = 8'h03;
    step();
    n_chk++;
    if (gnt !== 8'h02 || gnt_id !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_ptr1 got gnt=%h id=%0d want 02 1", gnt, gnt_id);
    end
  endtask

  task automatic test_fairness();
    int gap, wt;
    reset_dut();
    req = 8'hFF; en = 1;
    gap = 0;
    for (int g = 0; g < 9; g++) begin
      wt = 0;
      while (!gnt_vld && wt < 6) begin
        step(); wt++;
        if (!gnt_vld) gap++;
      end
      n_chk++;
      if (gnt_vld !== 1'b1 || gnt_id !== 3'(g % 8) || gnt !== m_gnt) begin
        n_fail++;
        $display("FAIL fair_seq%0d got id=%0d gnt=%h want id=%0d gnt=%h",
                 g, gnt_id, gnt, g % 8, m_gnt);
      end
      if (g > 0) begin
        n_chk++;
        if (gap != 2) begin
          n_fail++;
          $display("FAIL fair_gap%0d got %0d idle cycles want 2", g, gap);
        end
      end
      done = 1;
      step();
      done = 0;
      gap = gnt_vld ? 0 : 1;
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    req = 8'h20; en = 1;
    step();
    n_chk++;
    if (gnt_id !== 3'd5) begin
      n_fail++; $display("FAIL wrap_setup got id=%0d want 5", gnt_id);
    end
    done = 1; req = 8'h00;
    step();
    done = 0;
    step();
    req = 8'h05;
    step();
    n_chk++;
    if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_win0 got gnt=%h id=%0d want 01 0", gnt, gnt_id);
    end
    done = 1;
    step();
    done = 0;
    step();
    step();
    n_chk++;
    if (gnt !== 8'h04 || gnt_id !== 3'd2) begin
      n_fail++;
      $display("FAIL wrap_win2 got gnt=%h id=%0d want 04 2", gnt, gnt_id);
    end
  endtask

  task automatic test_timeout();
    int n;
    reset_dut();
    req = 8'h08; en = 1;
    step();
    n = 0;
    while (gnt === 8'h08 && n < 10) begin
      n++;
      step();
    end
    n_chk++;
    if (n != MH) begin
      n_fail++; $display("FAIL to_hold got %0d cycles want %0d", n, MH);
    end
    n_chk++;
    if (timeout !== 1'b1 || gnt !== 8'h00) begin
      n_fail++;
      $display("FAIL to_pulse got to=%b gnt=%h want 1 00", timeout, gnt);
    end
    req = 8'h00;
    step();
    n_chk++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_onecycle got %b want 0", timeout);
    end
  endtask

  task automatic test_simul_exit();
    reset_dut();
    req = 8'h08; en = 1;
    step();
    repeat (MH - 1) step();
    n_chk++;
    if (gnt !== 8'h08) begin
      n_fail++; $display("FAIL sim_held got %h want 08", gnt);
    end
    done = 1;
    step();
    n_chk++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_exit got gnt=%h to=%b want 00 0", gnt, timeout);
    end
    done = 0; en = 0; req = 8'hFF;
    repeat (4) step();
    n_chk++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_en0 got gnt=%h vld=%b want 00 0", gnt, gnt_vld);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    req = 8'h04; en = 1;
    step();
    step();
    #3;
    rst = 1;
    #1;
    n_chk++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_id !== 3'd0) begin
      n_fail++;
      $display("FAIL arst_drop got gnt=%h vld=%b id=%0d want 00 0 0",
               gnt, gnt_vld, gnt_id);
    end
    step();
    n_chk++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL arst_noto got %b want 0", timeout);
    end
    rst = 0;
    model_reset();
    req = 8'h81;
    step();
    n_chk++;
    if (gnt_id !== 3'd0 || gnt !== 8'h01) begin
      n_fail++;
      $display("FAIL arst_ptr0 got id=%0d gnt=%h want 0 01", gnt_id, gnt);
    end
    done = 1;
    step();
    done = 0; req = 8'h80;
    step();
    step();
    n_chk++;
    if (gnt_id !== 3'd7 || gnt !== 8'h80) begin
      n_fail++;
      $display("FAIL arst_id7 got id=%0d gnt=%h want 7 80", gnt_id, gnt);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      en   = ($urandom_range(0, 7) != 0);
      done = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: req = 8'h00;
        1: req = 8'(1 << $urandom_range(0, 7));
        default: req = 8'($urandom);
      endcase
      // keep the owner requesting most of the time so timeouts occur
      if (m_busy && $urandom_range(0, 3) != 0) begin
        req[m_owner] = 1'b1;
        done = ($urandom_range(0, 5) == 0);
      end
      step();
      n_chk++;
      if (gnt !== m_gnt || gnt_vld !== m_busy || timeout !== m_to ||
          (m_busy && gnt_id !== 3'(m_owner))) begin
        n_fail++;
        $display("FAIL rand_c%0d got gnt=%h vld=%b to=%b id=%0d want %h %b %b %0d",
                 c, gnt, gnt_vld, timeout, gnt_id,
                 m_gnt, m_busy, m_to, m_owner);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_fairness();
    test_wrap();
    test_timeout();
    test_simul_exit();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
